// File: rtl/shft_seq.sv
// Sequential zero-fill shifter: loads an (N+1)-bit word, shifts it one bit per clock
// for a requested count, and streams every shifted-out bit with a qualifier.
module shft_seq #(
    parameter int         N    = 7,
    parameter int         CW   = 4,
    parameter logic [N:0] INIT = 8'hAA
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          strt,
    input  logic          shftdir,
    input  logic [CW-1:0] Noofshfts,
    input  logic [N:0]    din,
    output logic [N:0]    Q,
    output logic          sout,
    output logic          sout_vld,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [N:0]    q_q;
    logic [CW-1:0] cnt_q;
    logic          dir_q;
    logic          sout_q;
    logic          sout_vld_q;
    logic          busy_q;
    logic          done_q;

    logic [N:0]    q_d;
    logic          sout_d;

    // q_d is the word after one more shift; sout_d is the bit that shift will emit next.
    always_comb begin
        q_d    = dir_q ? {q_q[N-1:0], 1'b0} : {1'b0, q_q[N:1]};
        sout_d = dir_q ? q_d[N] : q_d[0];
    end

    // sout/sout_vld are registered one edge early so they present the bit leaving
    // Q during the same cycle in which busy is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            q_q        <= INIT;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            sout_q     <= 1'b0;
            sout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (strt) begin
                        q_q   <= din;
                        cnt_q <= Noofshfts;
                        dir_q <= shftdir;
                        if (Noofshfts != '0) begin
                            state_q    <= S_SHIFT;
                            busy_q     <= 1'b1;
                            sout_q     <= shftdir ? din[N] : din[0];
                            sout_vld_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        sout_q     <= 1'b0;
                        sout_vld_q <= 1'b0;
                    end else begin
                        sout_q     <= sout_d;
                        sout_vld_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    sout_q     <= 1'b0;
                    sout_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign Q        = q_q;
    assign sout     = sout_q;
    assign sout_vld = sout_vld_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_shft_seq.sv
// Scoreboard bench for shft_seq: stimulus queues hand-computed serial bits and final
// words with their expected cycle; a negedge monitor pops and compares them.
module tb_shft_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       strt = 1'b0;
    logic       shftdir = 1'b0;
    logic [3:0] Noofshfts = '0;
    logic [7:0] din = '0;
    logic [7:0] Q;
    logic       sout;
    logic       sout_vld;
    logic       busy;
    logic       done;

    shft_seq #(.N(7), .CW(4), .INIT(8'hAA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt      (strt),
        .shftdir   (shftdir),
        .Noofshfts (Noofshfts),
        .din       (din),
        .Q         (Q),
        .sout      (sout),
        .sout_vld  (sout_vld),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    // Monitor: every qualified serial bit and every done pulse must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sout_vld) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    chk("unexpected_sout", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sout_bit", {31'd0, sout}, {31'd0, e.val[0]});
                    chk("sout_cycle", cyc_cnt, e.cyc);
                end
            end
            if (done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_q", {24'd0, Q}, {24'd0, e.val});
                    chk("done_cycle", cyc_cnt, e.cyc);
                end
            end
        end
    end

    // Called at a negedge in IDLE. bits[i] is the i-th expected serial bit.
    task automatic run_op(input logic [7:0] d, input bit dir, input logic [3:0] k,
                          input logic [15:0] bits, input logic [7:0] eq, input bit poke);
        int acc;
        bit seen;
        acc = cyc_cnt + 1;
        din = d; shftdir = dir; Noofshfts = k; strt = 1'b1;
        for (int i = 0; i < int'(k); i++) sb.push_back('{1'b0, {7'd0, bits[i]}, acc + i});
        sb.push_back('{1'b1, eq, acc + int'(k)});
        @(negedge clk);
        strt = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, {31'd0, (k != 0)});
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                shftdir = ~shftdir;
                strt = (poke && t == 1);
                @(negedge clk);
            end
        end
        strt = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("final_q", {24'd0, Q}, {24'd0, eq});
        if (poke) strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        chk("idle_after", {30'd0, busy, done}, 32'd0);
        $display("op din=%02h dir=%0d n=%0d -> Q=%02h", d, dir, k, Q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dcount;
        bit  seen;
        int  acc;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_q", {24'd0, Q}, 32'hAA);
        chk("reset_ctrl", {29'd0, busy, done, sout_vld}, 32'd0);
        chk("reset_sout", {31'd0, sout}, 32'd0);
        #19 rst_n = 1'b1;
        @(negedge clk);

        run_op(8'hAA, 1'b0, 4'd3,  16'h0002, 8'h15, 1'b1);
        run_op(8'h81, 1'b1, 4'd2,  16'h0001, 8'h04, 1'b0);
        run_op(8'h5A, 1'b0, 4'd0,  16'h0000, 8'h5A, 1'b0);
        run_op(8'hFF, 1'b0, 4'd15, 16'h00FF, 8'h00, 1'b1);
        run_op(8'h01, 1'b1, 4'd15, 16'h0080, 8'h00, 1'b0);
        run_op(8'h3C, 1'b1, 4'd4,  16'h000C, 8'hC0, 1'b0);
        run_op(8'h01, 1'b0, 4'd1,  16'h0001, 8'h00, 1'b0);

        // strt held high: two back-to-back single-shift operations
        acc = cyc_cnt + 1;
        din = 8'h81; shftdir = 1'b1; Noofshfts = 4'd1; strt = 1'b1;
        sb.push_back('{1'b0, 8'h01, acc});
        sb.push_back('{1'b1, 8'h02, acc + 1});
        sb.push_back('{1'b0, 8'h01, acc + 3});
        sb.push_back('{1'b1, 8'h02, acc + 4});
        dcount = 0;
        for (int t = 0; t < 30 && dcount < 2; t++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        strt = 1'b0;
        chk("held_strt_dones", dcount, 32'd2);
        @(negedge clk);
        chk("held_idle_after", {30'd0, busy, done}, 32'd0);
        $display("held strt: %0d operations completed", dcount);

        // asynchronous reset while idle, mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_q", {24'd0, Q}, 32'hAA);
        chk("async_reset_ctrl", {29'd0, busy, done, sout_vld}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // reset on the second cycle of a 5-shift operation
        acc = cyc_cnt + 1;
        din = 8'h0F; shftdir = 1'b0; Noofshfts = 4'd5; strt = 1'b1;
        sb.push_back('{1'b0, 8'h01, acc});
        sb.push_back('{1'b0, 8'h01, acc + 1});
        @(negedge clk);
        strt = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midshift_reset_q", {24'd0, Q}, 32'hAA);
        chk("midshift_reset_ctrl", {29'd0, busy, done, sout_vld}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("no_done_after_abort", {31'd0, seen}, 32'd0);
        $display("mid-shift reset: Q=%02h", Q);

        run_op(8'h3C, 1'b1, 4'd4, 16'h000C, 8'hC0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shft_seq.md
Name: shft_seq

Overview:
- Clocked, multi-cycle counterpart to the team's combinational shift-by-N datapath.
- Loads an (N+1)-bit word and shifts it one position per clock, left or right with zero fill, for a requested number of positions.
- Also transmits each bit it shifts out as a qualified serial stream, so a downstream serial consumer can rebuild the lost bits.
- Start/busy/done handshake.

Parameters:
- N, 7, MSB index; data width is N+1.
- CW, 4, width of the shift-count input.
- INIT, 8'hAA, reset value of Q; width N+1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- strt, input, 1, start request; sampled only in IDLE.
- shftdir, input, 1, direction: 0 = right (Q[i] <= Q[i+1], MSB filled 0); 1 = left (Q[i+1] <= Q[i], LSB filled 0).
- Noofshfts, input, CW, number of single-bit shifts to perform.
- din, input, N+1, word loaded on accepted strt.
- Q, output, N+1, working/result register.
- sout, output, 1, bit shifted out this cycle: Q[0] for right, Q[N] for left.
- sout_vld, output, 1, qualifies sout.
- busy, output, 1, high from the cycle after an accepted strt until done.
- done, output, 1, one-cycle pulse when the result in Q is final.

Behaviour:
- Reset (async, rst_n=0):
  - Q=INIT, state=IDLE.
  - busy=0, done=0, sout=0, sout_vld=0.
  - Internal count=0, latched direction=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, sout_vld=0, Q holds.
  - strt=1 at a clock edge:
    - Q<=din.
    - cnt<=Noofshfts.
    - dir<=shftdir (direction is latched; shftdir changes mid-operation are ignored).
  - Next state: SHIFT if Noofshfts!=0, else DONE.
- SHIFT:
  - busy=1.
  - On each edge:
    - Shift Q one position per the latched dir, zero fill.
    - Drive sout = the outgoing bit (pre-shift Q[0] or Q[N]).
    - Set sout_vld=1 for that cycle.
    - cnt<=cnt-1.
  - When cnt==1 at the edge, the final shift occurs and next state is DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle, sout_vld=0.
  - Next state: IDLE.
- Latency:
  - done asserts Noofshfts+1 cycles after the accepting edge.
  - Exactly Noofshfts sout_vld pulses occur, consecutive, first bit = first bit shifted out.
- Count boundaries:
  - Noofshfts=0: Q=din unchanged, no sout_vld, done one cycle after acceptance.
  - Noofshfts>=N+1: Q becomes all zeros after the (N+1)th shift. Remaining shifts continue and emit sout=0 with sout_vld=1; no early exit.
  - Max count 2^CW-1 is honoured.
- Handshake:
  - strt while busy or in DONE is ignored; it is not queued.
  - strt held high continuously re-triggers on the IDLE cycle after DONE.
- Reset mid-operation: immediate return to the reset values; the in-flight shift is abandoned and done is not asserted.
- Q is stable and readable in IDLE. In SHIFT, Q shows intermediate values.

Test Plan:
- Reset check: rst_n=0 asynchronously mid-cycle -> Q=8'hAA, busy=0, done=0, sout_vld=0 before the next clock edge.
- Right shift: din=8'hAA, shftdir=0, Noofshfts=3, strt pulse -> sout sequence 0,1,0 on three consecutive sout_vld cycles; final Q=8'h15; done 4 cycles after acceptance.
- Left shift, direction latch: din=8'h81, shftdir=1, Noofshfts=2; toggle shftdir during SHIFT -> sout 1,0; Q=8'h04; toggle has no effect.
- Boundary counts:
  - Noofshfts=0, din=8'h5A -> Q=8'h5A, no sout_vld, done 1 cycle after acceptance.
  - Noofshfts=15, din=8'hFF, right -> Q=8'h00; 15 sout_vld pulses (eight 1s, then seven 0s).
- Handshake: strt pulsed again during SHIFT -> ignored, single done. strt held high -> back-to-back operations, one IDLE cycle between done and the next busy.
- Reset mid-shift: rst_n low on cycle 2 of a 5-shift operation -> Q=8'hAA, state IDLE, no done pulse. A new strt after release operates normally.
